// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_pkg;

    localparam int unsigned MemAw = 30;
    localparam int unsigned MemDw = 32;

    // Reads always fetch the whole word.
    localparam logic [3:0] RdByteEn = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAck
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnWb,
        OwnD,
        OwnI
    } owner_e;

    // Next value of one requester's starvation counter. The counter only moves at an
    // IDLE grant (arb); it is cleared whenever the requester is idle or wins.
    function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                               input logic       req,
                                               input logic       arb,
                                               input logic       won,
                                               input logic [3:0] limit);
        logic [3:0] nxt;
        nxt = cnt;
        if (!req) begin
            nxt = 4'd0;
        end else if (arb) begin
            if (won) begin
                nxt = 4'd0;
            end else if (cnt < limit) begin
                nxt = cnt + 4'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/arb_prio3.sv
// Combinational 3-way fixed-priority pick; starved requesters form a higher tier.
// Slot 0 is the highest priority within each tier.
module arb_prio3 (
    input  logic [2:0] i_req,
    input  logic [2:0] i_starved,
    output logic [2:0] o_gnt,
    output logic       o_any
);

    logic [2:0] w_cand;

    // Choose the tier, then take the lowest-index candidate within it.
    always_comb begin
        w_cand = i_req & i_starved;
        if (w_cand == 3'b000) begin
            w_cand = i_req;
        end
        o_gnt = 3'b000;
        if (w_cand[0]) begin
            o_gnt = 3'b001;
        end else if (w_cand[1]) begin
            o_gnt = 3'b010;
        end else if (w_cand[2]) begin
            o_gnt = 3'b100;
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: write buffer, dcache and icache share one memory port.
// One operation at a time through IDLE -> BUSY -> ACK, with a BUSY timeout.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW           = MemAw,
    parameter int unsigned DW           = MemDw,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          swc,
    input  logic          wbreq,
    input  logic [AW-1:0] wbadr,
    input  logic [DW-1:0] wbdata,
    input  logic [3:0]    wbbyteen,
    output logic          wbdone,
    input  logic          dreq,
    input  logic [AW-1:0] dadr,
    output logic          ddone,
    input  logic          ireq,
    input  logic [AW-1:0] iadr,
    output logic          idone,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] memadr,
    output logic [DW-1:0] memwdata,
    output logic [3:0]    membyteen,
    output logic          memrwb,
    output logic          memen,
    input  logic [DW-1:0] memrdata,
    input  logic          memdone,
    output logic          err
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
    localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);

    state_e        r_state, w_state_nxt;
    owner_e        r_owner, w_owner_nxt;
    logic [AW-1:0] r_memadr, w_memadr_nxt;
    logic [DW-1:0] r_memwdata, w_memwdata_nxt;
    logic [3:0]    r_membyteen, w_membyteen_nxt;
    logic          r_memrwb, w_memrwb_nxt;
    logic          r_memen, w_memen_nxt;
    logic [DW-1:0] r_rdata, w_rdata_nxt;
    logic          r_wbdone, w_wbdone_nxt;
    logic          r_ddone, w_ddone_nxt;
    logic          r_idone, w_idone_nxt;
    logic          r_err, w_err_nxt;
    logic [7:0]    r_tmo, w_tmo_nxt;
    logic [3:0]    r_stv_wb, r_stv_d, r_stv_i;
    logic [3:0]    w_stv_wb_nxt, w_stv_d_nxt, w_stv_i_nxt;

    logic [2:0]    w_req_slot, w_stv_slot, w_gnt_slot;
    logic          w_any, w_arb;
    logic          w_gnt_wb, w_gnt_d, w_gnt_i;

    // Slot order is wb, primary, secondary; swc decides which cache is primary.
    assign w_req_slot = {swc ? dreq : ireq, swc ? ireq : dreq, wbreq};
    assign w_stv_slot = {swc ? (r_stv_d == StarveMax) : (r_stv_i == StarveMax),
                         swc ? (r_stv_i == StarveMax) : (r_stv_d == StarveMax),
                         r_stv_wb == StarveMax};

    arb_prio3 u_prio (
        .i_req     (w_req_slot),
        .i_starved (w_stv_slot),
        .o_gnt     (w_gnt_slot),
        .o_any     (w_any)
    );

    assign w_gnt_wb = w_gnt_slot[0];
    assign w_gnt_d  = swc ? w_gnt_slot[2] : w_gnt_slot[1];
    assign w_gnt_i  = swc ? w_gnt_slot[1] : w_gnt_slot[2];
    assign w_arb    = (r_state == StIdle) && w_any;

    // Starvation bookkeeping: losers at a grant count up, winners and idle requesters clear.
    always_comb begin
        w_stv_wb_nxt = starve_next(r_stv_wb, wbreq, w_arb, w_gnt_wb, StarveMax);
        w_stv_d_nxt  = starve_next(r_stv_d,  dreq,  w_arb, w_gnt_d,  StarveMax);
        w_stv_i_nxt  = starve_next(r_stv_i,  ireq,  w_arb, w_gnt_i,  StarveMax);
    end

    // FSM next state and registered memory-side / requester-side outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_memadr_nxt    = r_memadr;
        w_memwdata_nxt  = r_memwdata;
        w_membyteen_nxt = r_membyteen;
        w_memrwb_nxt    = r_memrwb;
        w_memen_nxt     = r_memen;
        w_rdata_nxt     = r_rdata;
        w_tmo_nxt       = r_tmo;
        w_wbdone_nxt    = 1'b0;
        w_ddone_nxt     = 1'b0;
        w_idone_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_wb) begin
                    w_owner_nxt     = OwnWb;
                    w_memadr_nxt    = wbadr;
                    w_memwdata_nxt  = wbdata;
                    w_membyteen_nxt = wbbyteen;
                    w_memrwb_nxt    = 1'b0;
                end else if (w_gnt_d) begin
                    w_owner_nxt     = OwnD;
                    w_memadr_nxt    = dadr;
                    w_membyteen_nxt = RdByteEn;
                    w_memrwb_nxt    = 1'b1;
                end else if (w_gnt_i) begin
                    w_owner_nxt     = OwnI;
                    w_memadr_nxt    = iadr;
                    w_membyteen_nxt = RdByteEn;
                    w_memrwb_nxt    = 1'b1;
                end
                if (w_any) begin
                    w_memen_nxt = 1'b1;
                    w_tmo_nxt   = 8'd0;
                    w_state_nxt = StBusy;
                end
            end
            StBusy: begin
                if (memdone) begin
                    if (r_memrwb) begin
                        w_rdata_nxt = memrdata;
                    end
                    w_memen_nxt = 1'b0;
                    w_state_nxt = StAck;
                    // Pulse lands in ACK, the same cycle rdata becomes valid.
                    unique case (r_owner)
                        OwnWb:   w_wbdone_nxt = 1'b1;
                        OwnD:    w_ddone_nxt  = 1'b1;
                        OwnI:    w_idone_nxt  = 1'b1;
                        default: ;
                    endcase
                end else if (r_tmo == TmoLast) begin
                    // Abort without a done; the requester still holds req and retries.
                    w_memen_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_owner_nxt = OwnNone;
                    w_state_nxt = StIdle;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            StAck: begin
                w_owner_nxt = OwnNone;
                w_state_nxt = StIdle;
            end
            default: begin
                w_owner_nxt = OwnNone;
                w_memen_nxt = 1'b0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_owner     <= OwnNone;
            r_memadr    <= '0;
            r_memwdata  <= '0;
            r_membyteen <= 4'd0;
            r_memrwb    <= 1'b1;
            r_memen     <= 1'b0;
            r_rdata     <= '0;
            r_wbdone    <= 1'b0;
            r_ddone     <= 1'b0;
            r_idone     <= 1'b0;
            r_err       <= 1'b0;
            r_tmo       <= 8'd0;
            r_stv_wb    <= 4'd0;
            r_stv_d     <= 4'd0;
            r_stv_i     <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_memadr    <= w_memadr_nxt;
            r_memwdata  <= w_memwdata_nxt;
            r_membyteen <= w_membyteen_nxt;
            r_memrwb    <= w_memrwb_nxt;
            r_memen     <= w_memen_nxt;
            r_rdata     <= w_rdata_nxt;
            r_wbdone    <= w_wbdone_nxt;
            r_ddone     <= w_ddone_nxt;
            r_idone     <= w_idone_nxt;
            r_err       <= w_err_nxt;
            r_tmo       <= w_tmo_nxt;
            r_stv_wb    <= w_stv_wb_nxt;
            r_stv_d     <= w_stv_d_nxt;
            r_stv_i     <= w_stv_i_nxt;
        end
    end

    assign memadr    = r_memadr;
    assign memwdata  = r_memwdata;
    assign membyteen = r_membyteen;
    assign memrwb    = r_memrwb;
    assign memen     = r_memen;
    assign rdata     = r_rdata;
    assign wbdone    = r_wbdone;
    assign ddone     = r_ddone;
    assign idone     = r_idone;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle table for basic write/read flow, then hand sequences.
module tb_mem_arbiter;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          swc;
    logic          wbreq, dreq, ireq;
    logic [AW-1:0] wbadr, dadr, iadr;
    logic [DW-1:0] wbdata;
    logic [3:0]    wbbyteen;
    logic          wbdone, ddone, idone, err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] memadr;
    logic [DW-1:0] memwdata;
    logic [3:0]    membyteen;
    logic          memrwb, memen;
    logic [DW-1:0] memrdata;
    logic          memdone;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (4),
        .TIMEOUT      (255)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .swc       (swc),
        .wbreq     (wbreq),
        .wbadr     (wbadr),
        .wbdata    (wbdata),
        .wbbyteen  (wbbyteen),
        .wbdone    (wbdone),
        .dreq      (dreq),
        .dadr      (dadr),
        .ddone     (ddone),
        .ireq      (ireq),
        .iadr      (iadr),
        .idone     (idone),
        .rdata     (rdata),
        .memadr    (memadr),
        .memwdata  (memwdata),
        .membyteen (membyteen),
        .memrwb    (memrwb),
        .memen     (memen),
        .memrdata  (memrdata),
        .memdone   (memdone),
        .err       (err)
    );

    // Memory model: memdone after mem_lat enabled cycles (0 = never answers).
    int            mem_lat = 1;
    int            mcnt = 0;
    logic [AW-1:0] last_wr_adr = '0;
    logic [DW-1:0] last_wr_data = '0;
    logic [3:0]    last_wr_be = 4'd0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 30'h0AD) return 32'hBEADBEEF;
        if (a == 30'h123) return 32'h11112222;
        return {2'b00, a} ^ 32'h5A5A0000;
    endfunction

    initial begin
        memdone  = 1'b0;
        memrdata = '0;
    end

    always @(posedge clk) begin
        if (!memen || memdone) begin
            memdone <= 1'b0;
            mcnt    <= 0;
        end else if (mem_lat != 0) begin
            if (mcnt == mem_lat - 1) begin
                memdone <= 1'b1;
                if (memrwb) begin
                    memrdata <= mem_word(memadr);
                end else begin
                    last_wr_adr  <= memadr;
                    last_wr_data <= memwdata;
                    last_wr_be   <= membyteen;
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int n_wb = 0, n_d = 0, n_i = 0, n_err = 0, n_memen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled at the following negedge and pulses tallied.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n_wb    += int'(wbdone);
        n_d     += int'(ddone);
        n_i     += int'(idone);
        n_err   += int'(err);
        n_memen += int'(memen);
    endtask

    function automatic logic pulse_of(input int sel);
        case (sel)
            0:       return wbdone;
            1:       return ddone;
            2:       return idone;
            default: return err;
        endcase
    endfunction

    // Bounded wait for a pulse; an expired budget is a failed comparison.
    task automatic wait_for(input string name, input int sel, input int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            seen = pulse_of(sel);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s actual=timeout expected=pulse within %0d cycles", name, budget);
        end
    endtask

    // exp = {memen, memrwb, wbdone, ddone, idone, err}
    typedef struct {
        logic        rst;
        logic        wb;
        logic        d;
        logic        i;
        logic        sw;
        logic [5:0]  exp;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [0:12];

    initial begin
        int s_wb, s_d, s_i, s_me;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b110000, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b110000, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b010100, 1'b1, 32'hBEADBEEF};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010000, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110000, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110000, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010, 1'b1, 32'h11112222};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000, 1'b1, 32'h11112222};

        wbadr    = 30'h4AD;
        wbdata   = 32'hDDCCBBAA;
        wbbyteen = 4'hF;
        dadr     = 30'h0AD;
        iadr     = 30'h123;
        reset    = 1'b0;
        swc      = 1'b0;
        wbreq    = 1'b0;
        dreq     = 1'b0;
        ireq     = 1'b0;

        // Write, then simultaneous D/I reads with D above I.
        for (int k = 0; k <= 12; k++) begin
            reset = vecs[k].rst;
            wbreq = vecs[k].wb;
            dreq  = vecs[k].d;
            ireq  = vecs[k].i;
            swc   = vecs[k].sw;
            tick();
            chk($sformatf("vec%0d_ctl", k),
                64'({memen, memrwb, wbdone, ddone, idone, err}), 64'(vecs[k].exp));
            if (vecs[k].chk_rd) begin
                chk($sformatf("vec%0d_rdata", k), 64'(rdata), 64'(vecs[k].exp_rd));
            end
        end
        chk("wr_adr", 64'(last_wr_adr), 64'h4AD);
        chk("wr_data", 64'(last_wr_data), 64'hDDCCBBAA);
        chk("wr_be", 64'(last_wr_be), 64'hF);

        // swc=1: I first; flipping swc mid-BUSY must not steal the grant.
        swc  = 1'b1;
        dreq = 1'b1;
        ireq = 1'b1;
        s_d  = n_d;
        tick();
        chk("swap_adr", 64'(memadr), 64'h123);
        chk("swap_be", 64'(membyteen), 64'hF);
        swc = 1'b0;
        wait_for("swap_idone", 2, 20);
        chk("swap_rdata_i", 64'(rdata), 64'h11112222);
        chk("swap_no_ddone", 64'(n_d - s_d), 64'd0);
        ireq = 1'b0;
        wait_for("swap_ddone", 1, 20);
        chk("swap_rdata_d", 64'(rdata), 64'hBEADBEEF);
        dreq = 1'b0;
        tick();

        // Continuous WB traffic: I forced through after four WB grants.
        wbreq = 1'b1;
        ireq  = 1'b1;
        s_wb  = n_wb;
        wait_for("starve_idone", 2, 100);
        chk("starve_wb_count", 64'(n_wb - s_wb), 64'd4);
        ireq = 1'b0;
        wait_for("starve_wb_after", 0, 20);
        wbreq = 1'b0;
        tick();
        tick();

        // Silent memory: abort after 255 BUSY cycles, then retry succeeds.
        mem_lat = 0;
        s_wb = n_wb; s_d = n_d; s_i = n_i; s_me = n_memen;
        dreq = 1'b1;
        wait_for("tmo_err", 3, 300);
        chk("tmo_memen", 64'(memen), 64'd0);
        chk("tmo_busy_cycles", 64'(n_memen - s_me), 64'd255);
        chk("tmo_no_done", 64'((n_wb - s_wb) + (n_d - s_d) + (n_i - s_i)), 64'd0);
        mem_lat = 1;
        wait_for("tmo_regrant", 1, 20);
        chk("tmo_err_once", 64'(n_err), 64'd1);
        dreq = 1'b0;
        tick();

        // Reset in the middle of an operation.
        mem_lat = 0;
        wbreq   = 1'b1;
        tick();
        chk("rst_busy_memen", 64'(memen), 64'd1);
        reset = 1'b0;
        s_wb  = n_wb;
        tick();
        chk("rst_ctl", 64'({memen, memrwb, wbdone, ddone, idone, err}), 64'b010000);
        chk("rst_mem", 64'({memadr, membyteen}), 64'd0);
        chk("rst_wdata", 64'(memwdata), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        reset = 1'b1;
        wbreq = 1'b0;
        mem_lat = 1;
        for (int k = 0; k < 5; k++) tick();
        chk("rst_no_done", 64'(n_wb - s_wb), 64'd0);
        chk("rst_idle_memen", 64'(memen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=no finish expected=finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
